// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall/flush
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    localparam logic [4:0] c_x0_addr = 5'd0;

    localparam pipe_ctrl_t c_ctrl_run = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                          exmem_en: 1'b1, memwb_en: 1'b1,
                                          ifid_flush: 1'b0, idex_flush: 1'b0,
                                          exmem_flush: 1'b0};

    localparam pipe_ctrl_t c_ctrl_freeze = '{default: 1'b0};

    // Front end frozen while the mul/div op sits in ID/EX; bubbles flow into EX/MEM.
    localparam pipe_ctrl_t c_ctrl_md_hold = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                              exmem_en: 1'b1, memwb_en: 1'b1,
                                              ifid_flush: 1'b0, idex_flush: 1'b0,
                                              exmem_flush: 1'b1};

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Hazard status inputs and pipeline register controls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;

    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd_addr;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_md_valid;
    logic       md_done;
    logic       im_wait;
    logic       dm_wait;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       md_start;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, ex_rd_addr,
               ex_mem_read, ex_branch_taken, ex_md_valid, md_done, im_wait, dm_wait,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, md_start
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, ex_rd_addr,
               ex_mem_read, ex_branch_taken, ex_md_valid, md_done, im_wait, dm_wait,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, md_start
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sat_counter
//  Description : Saturating event counter, holds at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : hazard_sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage RV32 pipeline with
//                saturating stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    pipeline_hazard_ctrl_if.slave   hz,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    hz_state_e  r_state;
    hz_state_e  w_state_nxt;
    logic       r_md_done_q;
    logic       w_md_done_q_nxt;
    pipe_ctrl_t w_ctrl;
    logic       w_md_start;
    logic       w_mem_wait;
    logic       w_load_use;

    assign w_mem_wait = hz.im_wait | hz.dm_wait;

    assign w_load_use = hz.ex_mem_read && (hz.ex_rd_addr != c_x0_addr) &&
                        ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                         (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_md_done_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_md_done_q <= w_md_done_q_nxt;
        end
    end

    always_comb begin
        w_ctrl          = c_ctrl_run;
        w_md_start      = 1'b0;
        w_state_nxt     = r_state;
        w_md_done_q_nxt = r_md_done_q;

        case (r_state)
            ST_MD_BUSY: begin
                if (w_mem_wait) begin
                    // A completion pulse during a memory wait must not be lost.
                    w_ctrl          = c_ctrl_freeze;
                    w_md_done_q_nxt = r_md_done_q | hz.md_done;
                end else if (hz.md_done || r_md_done_q) begin
                    w_md_done_q_nxt = 1'b0;
                    w_state_nxt     = ST_RUN;
                end else begin
                    w_ctrl = c_ctrl_md_hold;
                end
            end

            default: begin
                // MEM_WAIT resumes with the RUN decision since ID/EX were frozen.
                w_state_nxt = ST_RUN;
                if (w_mem_wait) begin
                    w_ctrl      = c_ctrl_freeze;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (hz.ex_md_valid) begin
                    w_ctrl      = c_ctrl_md_hold;
                    w_md_start  = 1'b1;
                    w_state_nxt = ST_MD_BUSY;
                end else if (hz.ex_branch_taken) begin
                    w_ctrl.ifid_flush = 1'b1;
                    w_ctrl.idex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_ctrl.pc_en      = 1'b0;
                    w_ctrl.ifid_en    = 1'b0;
                    w_ctrl.idex_flush = 1'b1;
                end
            end
        endcase
    end

    assign hz.pc_en       = rst_n & w_ctrl.pc_en;
    assign hz.ifid_en     = rst_n & w_ctrl.ifid_en;
    assign hz.idex_en     = rst_n & w_ctrl.idex_en;
    assign hz.exmem_en    = rst_n & w_ctrl.exmem_en;
    assign hz.memwb_en    = rst_n & w_ctrl.memwb_en;
    assign hz.ifid_flush  = rst_n & w_ctrl.ifid_flush;
    assign hz.idex_flush  = rst_n & w_ctrl.idex_flush;
    assign hz.exmem_flush = rst_n & w_ctrl.exmem_flush;
    assign hz.md_start    = rst_n & w_md_start;

    hazard_sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (~w_ctrl.pc_en),
        .o_count (stall_cnt)
    );

    hazard_sat_counter #(
        .WIDTH   (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_ctrl.ifid_flush),
        .o_count (flush_cnt)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire
